// File: rtl/seg7_to_bcd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seg7_to_bcd_monitor
// Brief    : Recovers BCD digits from an active-low 7-segment pattern, with a
//            glitch filter, valid/ready reporting and an illegal-pattern count.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_to_bcd_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             seg_enable,
    input  logic             bcd_ready,
    output logic [3:0]       bcd_out,
    output logic             bcd_valid,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [0:0] {
        TRACK   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [3:0]       STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [6:0]       SEG_BLANK  = 7'b1111111;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    state_t     state;
    logic [6:0] seg_q;
    logic [6:0] last_rep;
    logic [3:0] cnt;

    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       report_hit;

    // Segment order is a..g from bit6 down to bit0, lit when low.
    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'hF;
        case (seg_q)
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            SEG_BLANK:  dec_digit = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign report_hit = (cnt == STABLE_MAX) && (seg_q != last_rep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TRACK;
            seg_q     <= SEG_BLANK;
            last_rep  <= SEG_BLANK;
            cnt       <= 4'd0;
            bcd_out   <= 4'hF;
            bcd_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;

            // The stability filter keeps running while a digit is presented.
            if (!seg_enable) begin
                cnt <= 4'd0;
            end else if (seg_in != seg_q) begin
                seg_q <= seg_in;
                cnt   <= 4'd1;
            end else if (cnt != STABLE_MAX) begin
                cnt <= cnt + 4'd1;
            end

            case (state)
                TRACK: begin
                    if (report_hit) begin
                        last_rep <= seg_q;
                        if (dec_legal) begin
                            bcd_out   <= dec_digit;
                            bcd_valid <= 1'b1;
                            state     <= PRESENT;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                end
                PRESENT: begin
                    if (bcd_ready) begin
                        bcd_valid <= 1'b0;
                        state     <= TRACK;
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

endmodule
`default_nettype wire
